// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the core's fetch/data requesters, the arbiter and the memory macro.
// slave = arbiter view, master = environment (core + memory) view.
interface mem_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          if_valid;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [DW-1:0] d_rdata;
    logic          d_valid;
    logic          err;
    logic          busy;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ack;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
        output if_rdata, if_valid, d_rdata, d_valid, err, busy,
               mem_req, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
        input  if_rdata, if_valid, d_rdata, d_valid, err, busy,
               mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Serialises fetch and data accesses onto one memory port with a req/ack handshake,
// bounded fetch starvation and an optional response timeout.
module mem_port_arbiter #(
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int MAX_D_BURST = 4,
    parameter int TIMEOUT     = 64
) (
    input logic               clk,
    input logic               rst,
    mem_port_arbiter_if.slave bus
);
    localparam logic [3:0] MAXB = MAX_D_BURST[3:0];
    localparam logic [7:0] TMO  = TIMEOUT[7:0];

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

    state_e        state_q;
    logic          fetch_q;
    logic          store_q;
    logic [3:0]    streak_q;
    logic [7:0]    tmo_q;
    logic          mem_req_q;
    logic          mem_we_q;
    logic [AW-1:0] mem_addr_q;
    logic [DW-1:0] mem_wdata_q;
    logic [DW-1:0] if_rdata_q;
    logic [DW-1:0] d_rdata_q;
    logic          if_valid_q;
    logic          d_valid_q;
    logic          err_q;
    logic          busy_q;

    logic grant_d;
    logic tmo_hit;

    // Data wins ties until it has starved a waiting fetch MAX_D_BURST times in a row.
    assign grant_d = bus.d_req && !(bus.if_req && streak_q == MAXB);
    assign tmo_hit = (TMO != 8'd0) && (tmo_q + 8'd1 == TMO);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            fetch_q     <= 1'b0;
            store_q     <= 1'b0;
            streak_q    <= '0;
            tmo_q       <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            if_valid_q  <= 1'b0;
            d_valid_q   <= 1'b0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            if_valid_q <= 1'b0;
            d_valid_q  <= 1'b0;
            err_q      <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.d_req || bus.if_req) begin
                        state_q   <= BUSY;
                        busy_q    <= 1'b1;
                        mem_req_q <= 1'b1;
                        tmo_q     <= '0;
                        if (grant_d) begin
                            fetch_q     <= 1'b0;
                            store_q     <= bus.d_we;
                            mem_we_q    <= bus.d_we;
                            mem_addr_q  <= bus.d_addr;
                            mem_wdata_q <= bus.d_wdata;
                            if (bus.if_req)
                                streak_q <= (streak_q == MAXB) ? MAXB : streak_q + 4'd1;
                            else
                                streak_q <= '0;
                        end else begin
                            fetch_q    <= 1'b1;
                            store_q    <= 1'b0;
                            mem_we_q   <= 1'b0;
                            mem_addr_q <= bus.if_addr;
                            streak_q   <= '0;
                        end
                    end
                end
                BUSY: begin
                    tmo_q <= tmo_q + 8'd1;
                    // Ack takes priority over a timeout landing on the same cycle.
                    if (bus.mem_ack || tmo_hit) begin
                        state_q   <= DONE;
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                        err_q     <= !bus.mem_ack;
                        if (fetch_q) begin
                            if_valid_q <= 1'b1;
                            if_rdata_q <= bus.mem_ack ? bus.mem_rdata : '0;
                        end else begin
                            d_valid_q <= 1'b1;
                            if (!store_q)
                                d_rdata_q <= bus.mem_ack ? bus.mem_rdata : '0;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q   <= IDLE;
                    busy_q    <= 1'b0;
                    mem_req_q <= 1'b0;
                    mem_we_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.if_valid  = if_valid_q;
    assign bus.d_valid   = d_valid_q;
    assign bus.err       = err_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with MAX_D_BURST=4, TIMEOUT=5.
module tb_mem_port_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_assert = 0;
    int   n_fail = 0;

    mem_port_arbiter_if #(.AW(32), .DW(32)) bus ();

    mem_port_arbiter #(.AW(32), .DW(32), .MAX_D_BURST(4), .TIMEOUT(5)) dut (
        .clk (clk),
        .rst (rst_n),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [9:0] fetch_slot;
        fetch_slot = 10'b1000010000;

        bus.if_req = 0; bus.if_addr = 0; bus.d_req = 0; bus.d_we = 0;
        bus.d_addr = 0; bus.d_wdata = 0; bus.mem_rdata = 0; bus.mem_ack = 0;

        #2;
        chk("rst_mem_req", 32'(bus.mem_req), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_d_valid", 32'(bus.d_valid), 0);
        chk("rst_if_valid", 32'(bus.if_valid), 0);
        chk("rst_err", 32'(bus.err), 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_d_rdata", bus.d_rdata, 0);
        tick(); tick();
        rst_n = 1;
        tick();

        // single load, ack in the 3rd mem_req cycle
        bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h40;
        tick();
        chk("ld_req1", 32'(bus.mem_req), 1);
        chk("ld_we", 32'(bus.mem_we), 0);
        chk("ld_addr", bus.mem_addr, 32'h40);
        chk("ld_busy", 32'(bus.busy), 1);
        tick();
        chk("ld_req2", 32'(bus.mem_req), 1);
        tick();
        chk("ld_req3", 32'(bus.mem_req), 1);
        chk("ld_no_valid_yet", 32'(bus.d_valid), 0);
        bus.mem_ack = 1; bus.mem_rdata = 32'hDEADBEEF;
        tick();
        chk("ld_req_drop", 32'(bus.mem_req), 0);
        chk("ld_valid", 32'(bus.d_valid), 1);
        chk("ld_rdata", bus.d_rdata, 32'hDEADBEEF);
        chk("ld_err", 32'(bus.err), 0);
        chk("ld_if_valid", 32'(bus.if_valid), 0);
        bus.mem_ack = 0; bus.d_req = 0;
        tick();
        chk("ld_valid_pulse", 32'(bus.d_valid), 0);
        chk("ld_busy_drop", 32'(bus.busy), 0);

        // store, immediate ack; d_rdata must keep the load value
        bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h10; bus.d_wdata = 32'h1234;
        tick();
        chk("st_req", 32'(bus.mem_req), 1);
        chk("st_we", 32'(bus.mem_we), 1);
        chk("st_wdata", bus.mem_wdata, 32'h1234);
        chk("st_addr", bus.mem_addr, 32'h10);
        bus.mem_ack = 1; bus.mem_rdata = 32'h55555555;
        tick();
        chk("st_valid", 32'(bus.d_valid), 1);
        chk("st_we_drop", 32'(bus.mem_we), 0);
        chk("st_rdata_hold", bus.d_rdata, 32'hDEADBEEF);
        chk("st_err", 32'(bus.err), 0);
        bus.d_req = 0; bus.d_we = 0; bus.mem_ack = 0;
        tick();

        // contention: both requesters held, ack always ready
        bus.if_req = 1; bus.if_addr = 32'h100;
        bus.d_req = 1; bus.d_addr = 32'h200; bus.mem_ack = 1; bus.mem_rdata = 32'h77;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk($sformatf("cont_addr%0d", k), bus.mem_addr, fetch_slot[k] ? 32'h100 : 32'h200);
            tick();
            chk($sformatf("cont_ivld%0d", k), 32'(bus.if_valid), 32'(fetch_slot[k]));
            chk($sformatf("cont_dvld%0d", k), 32'(bus.d_valid), 32'(!fetch_slot[k]));
            tick();
        end
        bus.if_req = 0; bus.d_req = 0; bus.mem_ack = 0;
        tick();
        chk("cont_idle", 32'(bus.busy), 0);

        // timeout: load never acked
        bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h80;
        for (int c = 1; c <= 5; c++) begin
            tick();
            chk($sformatf("tmo_req%0d", c), 32'(bus.mem_req), 1);
        end
        tick();
        chk("tmo_valid", 32'(bus.d_valid), 1);
        chk("tmo_err", 32'(bus.err), 1);
        chk("tmo_rdata", bus.d_rdata, 0);
        chk("tmo_req_drop", 32'(bus.mem_req), 0);
        chk("tmo_busy", 32'(bus.busy), 1);
        bus.d_req = 0;
        tick();
        chk("tmo_busy_drop", 32'(bus.busy), 0);
        chk("tmo_err_clr", 32'(bus.err), 0);

        // ack coincident with the timeout cycle
        bus.d_req = 1; bus.d_addr = 32'h84;
        for (int c = 1; c <= 4; c++) tick();
        tick();
        chk("coin_req5", 32'(bus.mem_req), 1);
        bus.mem_ack = 1; bus.mem_rdata = 32'hCAFEF00D;
        tick();
        chk("coin_valid", 32'(bus.d_valid), 1);
        chk("coin_err", 32'(bus.err), 0);
        chk("coin_rdata", bus.d_rdata, 32'hCAFEF00D);
        bus.mem_ack = 0; bus.d_req = 0;
        tick();

        // reset mid-access, late ack, then normal fetch
        bus.if_req = 1; bus.if_addr = 32'h300;
        tick();
        chk("rm_req", 32'(bus.mem_req), 1);
        #2 rst_n = 0;
        #1;
        chk("rm_req_async", 32'(bus.mem_req), 0);
        chk("rm_busy_async", 32'(bus.busy), 0);
        bus.if_req = 0;
        tick();
        rst_n = 1;
        bus.mem_ack = 1; bus.mem_rdata = 32'h99;
        tick();
        chk("rm_late_ivld", 32'(bus.if_valid), 0);
        chk("rm_late_dvld", 32'(bus.d_valid), 0);
        chk("rm_late_req", 32'(bus.mem_req), 0);
        bus.if_req = 1; bus.if_addr = 32'h304; bus.mem_rdata = 32'h0BADC0DE;
        tick();
        chk("rm_if_req", 32'(bus.mem_req), 1);
        chk("rm_if_addr", bus.mem_addr, 32'h304);
        tick();
        chk("rm_if_valid", 32'(bus.if_valid), 1);
        chk("rm_if_rdata", bus.if_rdata, 32'h0BADC0DE);
        chk("rm_if_err", 32'(bus.err), 0);
        bus.if_req = 0; bus.mem_ack = 0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
